// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared types and constants for the RTC multiplexed-bus controller:
// state encoding and the menu-index to RTC-register address map.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_SETUP,
    ST_ADDR_STROBE,
    ST_ADDR_HOLD,
    ST_DATA_SETUP,
    ST_DATA_STROBE,
    ST_DATA_HOLD,
    ST_RECOVER,
    ST_DONE
  } state_e;

  localparam logic [7:0] ADDR_CMD   = 8'hF0;
  localparam logic [7:0] ADDR_TIMER = 8'h41;

  // Index 0 is the rightmost entry.
  localparam logic [7:0][7:0] ADDR_TBL = {
    ADDR_TIMER, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21, ADDR_CMD
  };

  function automatic logic [7:0] map_addr(input logic [2:0] dir);
    return ADDR_TBL[dir];
  endfunction

  function automatic logic is_timed(input state_e s);
    return !(s == ST_IDLE || s == ST_DONE);
  endfunction

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Menu-side request/response and RTC pad signals of the bus controller.
interface rtc_bus_ctrl_if;
  logic       Acceso;
  logic       Mod;
  logic [2:0] DIR;
  logic [7:0] WDATA;
  logic [7:0] AD_IN;
  logic [7:0] AD_OUT;
  logic       AD_OE;
  logic       CS_n;
  logic       RD_n;
  logic       WR_n;
  logic       AD_n;
  logic [7:0] RDATA;
  logic       RVALID;
  logic       FRW;
  logic       BUSY;

  modport slave (
    input  Acceso, Mod, DIR, WDATA, AD_IN,
    output AD_OUT, AD_OE, CS_n, RD_n, WR_n, AD_n, RDATA, RVALID, FRW, BUSY
  );

  modport master (
    output Acceso, Mod, DIR, WDATA, AD_IN,
    input  AD_OUT, AD_OE, CS_n, RD_n, WR_n, AD_n, RDATA, RVALID, FRW, BUSY
  );
endinterface

// File: rtl/rtc_phase_timer.sv
// Loadable down-counter: load sets T_PHASE-1, done flags the last cycle of a phase.
module rtc_phase_timer #(
  parameter int unsigned T_PHASE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic done
);
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)              cnt_d = 8'(T_PHASE - 1);
    else if (cnt_q != '0)  cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == 8'd0);
endmodule

// File: rtl/rtc_bus_ctrl.sv
// Turns one menu request into one RTC address+data bus cycle; all pad and
// handshake outputs are flops decoded from the current state.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_PHASE = 4
) (
  input  logic           CLK,
  input  logic           RST,
  rtc_bus_ctrl_if.slave  bus
);
  state_e     state_q, state_d;
  logic [2:0] dir_q, dir_d;
  logic       mod_q, mod_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] ad_out_q, ad_out_d, rdata_q, rdata_d;
  logic       ad_oe_q, ad_oe_d, cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic       ad_n_q, ad_n_d, rvalid_q, rvalid_d, frw_q, frw_d, busy_q, busy_d;
  logic       ph_load, ph_done;

  rtc_phase_timer #(.T_PHASE(T_PHASE)) u_timer (
    .clk   (CLK),
    .rst_n (RST),
    .load  (ph_load),
    .done  (ph_done)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    mod_d   = mod_q;
    wdata_d = wdata_q;
    unique case (state_q)
      ST_IDLE: if (bus.Acceso) begin
        state_d = ST_ADDR_SETUP;
        dir_d   = bus.DIR;
        mod_d   = bus.Mod;
        wdata_d = bus.WDATA;
      end
      ST_DONE: state_d = ST_IDLE;
      default: if (ph_done) state_d = state_e'(state_q + 4'd1);
    endcase
    ph_load = (state_d != state_q) && is_timed(state_d);
  end

  // Pins follow state_q one cycle later, which sets FRW at accept + 7*T_PHASE + 1.
  always_comb begin
    cs_n_d   = 1'b1;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    ad_n_d   = 1'b1;
    ad_oe_d  = 1'b0;
    ad_out_d = 8'h00;
    frw_d    = 1'b0;
    busy_d   = (state_q != ST_IDLE);
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    case (state_q)
      ST_ADDR_SETUP, ST_ADDR_STROBE, ST_ADDR_HOLD: begin
        cs_n_d   = 1'b0;
        ad_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = map_addr(dir_q);
        wr_n_d   = (state_q != ST_ADDR_STROBE);
      end
      ST_DATA_SETUP, ST_DATA_STROBE, ST_DATA_HOLD: begin
        cs_n_d = 1'b0;
        if (mod_q) begin
          ad_oe_d  = 1'b1;
          ad_out_d = wdata_q;
          wr_n_d   = (state_q != ST_DATA_STROBE);
        end else begin
          rd_n_d   = (state_q != ST_DATA_STROBE);
        end
      end
      ST_DONE: frw_d = 1'b1;
      default: ;
    endcase
    // Sample the pad on the last cycle the read strobe is low at the pin.
    if (!rd_n_q && rd_n_d) begin
      rdata_d  = bus.AD_IN;
      rvalid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      dir_q    <= '0;
      mod_q    <= 1'b0;
      wdata_q  <= '0;
      ad_out_q <= 8'h00;
      ad_oe_q  <= 1'b0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      ad_n_q   <= 1'b1;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
      frw_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      mod_q    <= mod_d;
      wdata_q  <= wdata_d;
      ad_out_q <= ad_out_d;
      ad_oe_q  <= ad_oe_d;
      cs_n_q   <= cs_n_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
      ad_n_q   <= ad_n_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      frw_q    <= frw_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.AD_OUT = ad_out_q;
  assign bus.AD_OE  = ad_oe_q;
  assign bus.CS_n   = cs_n_q;
  assign bus.RD_n   = rd_n_q;
  assign bus.WR_n   = wr_n_q;
  assign bus.AD_n   = ad_n_q;
  assign bus.RDATA  = rdata_q;
  assign bus.RVALID = rvalid_q;
  assign bus.FRW    = frw_q;
  assign bus.BUSY   = busy_q;
endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Directed bench: T_PHASE=4 instance with a scoreboard-checked monitor and a
// T_PHASE=1 instance checked inline.
module tb_rtc_bus_ctrl;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  rtc_bus_ctrl_if b4();
  rtc_bus_ctrl_if b1();

  rtc_bus_ctrl #(.T_PHASE(4)) dut4 (.CLK(CLK), .RST(RST), .bus(b4));
  rtc_bus_ctrl #(.T_PHASE(1)) dut1 (.CLK(CLK), .RST(RST), .bus(b1));

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    bit         rd;
    int         frw_cyc;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] rd_val = 8'h59;
  logic [7:0] tbl [8] = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41};

  // RTC model: drives read data only while the read strobe is low.
  always @(negedge CLK) begin
    b4.AD_IN = !b4.RD_n ? rd_val : 8'hEE;
    b1.AD_IN = !b1.RD_n ? 8'hA5 : 8'hEE;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Per-transaction observations on the T_PHASE=4 bus.
  bit         a_seen, a_bad, d_seen;
  logic [7:0] a_val, d_val, rv_data;
  int         rd_low, wr_low, wr_pulses, viol, rv_cnt;
  logic       wr_prev = 1'b1, frw_prev = 1'b0;

  task automatic mon_clr();
    a_seen = 0; a_bad = 0; d_seen = 0;
    a_val = 0; d_val = 0; rv_data = 0;
    rd_low = 0; wr_low = 0; wr_pulses = 0; viol = 0; rv_cnt = 0;
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (!RST) mon_clr();
    else begin
      if (!b4.CS_n && !b4.AD_n && b4.AD_OE) begin
        if (a_seen && b4.AD_OUT != a_val) a_bad = 1;
        a_val = b4.AD_OUT; a_seen = 1;
      end
      if (!b4.CS_n && b4.AD_n && b4.AD_OE) begin d_val = b4.AD_OUT; d_seen = 1; end
      if (!b4.RD_n) rd_low++;
      if (!b4.WR_n) wr_low++;
      if (!b4.WR_n && wr_prev) wr_pulses++;
      if (!b4.RD_n && !b4.WR_n) viol++;
      if (b4.AD_OE && !b4.RD_n) viol++;
      if (b4.RVALID) begin rv_cnt++; rv_data = b4.RDATA; end
      if (b4.FRW) begin
        chk("frw_width", frw_prev, 0);
        if (sb.size() == 0) chk("frw_spurious", 1, 0);
        else begin
          e = sb.pop_front();
          chk("frw_latency", cyc, e.frw_cyc);
          chk("addr", a_val, e.addr);
          chk("addr_stable", {a_seen, a_bad}, 2'b10);
          chk("rd_low_cycles", rd_low, e.rd ? 4 : 0);
          chk("wr_low_cycles", wr_low, e.rd ? 4 : 8);
          chk("wr_pulses", wr_pulses, e.rd ? 1 : 2);
          chk("rvalid_count", rv_cnt, e.rd ? 1 : 0);
          chk("strobe_overlap", viol, 0);
          if (e.rd) begin
            chk("rdata", rv_data, e.data);
            chk("rd_no_drive", d_seen, 0);
          end else begin
            chk("wdata", {d_seen, d_val}, {1'b1, e.data});
          end
          mon_clr();
        end
      end
    end
    wr_prev  = b4.WR_n;
    frw_prev = b4.FRW;
  end

  // Called on a negedge; the request is accepted at the following posedge.
  task automatic start(input logic [2:0] dir, input logic mod, input logic [7:0] wd, input bit push);
    exp_t e;
    b4.DIR = dir; b4.Mod = mod; b4.WDATA = wd; b4.Acceso = 1'b1;
    e.addr = tbl[dir]; e.data = mod ? wd : rd_val; e.rd = !mod; e.frw_cyc = cyc + 30;
    if (push) sb.push_back(e);
  endtask

  task automatic wait_frw(input string tag);
    bit hit = 0;
    for (int i = 0; i < 45 && !hit; i++) begin
      @(negedge CLK);
      hit = b4.FRW;
    end
    chk(tag, hit, 1);
  endtask

  initial begin
    bit         hit, frw_seen;
    int         t0, n_rd, n_wr, n_rv;
    logic [7:0] a1, r1;

    RST = 1'b0;
    b4.Acceso = 1'b1; b4.Mod = 1'b0; b4.DIR = 3'd0; b4.WDATA = 8'h00;
    b1.Acceso = 1'b1; b1.Mod = 1'b0; b1.DIR = 3'd0; b1.WDATA = 8'h00;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_strobes", {b4.CS_n, b4.RD_n, b4.WR_n, b4.AD_n}, 4'hF);
      chk("rst_oe_frw", {b4.AD_OE, b4.FRW, b4.BUSY, b4.RVALID}, 4'h0);
      chk("rst_data", {b4.AD_OUT, b4.RDATA}, 16'h0000);
    end
    RST = 1'b1; b4.Acceso = 1'b0; b1.Acceso = 1'b0;
    @(negedge CLK);
    chk("post_rst_idle", {b4.BUSY, b4.CS_n}, 2'b01);

    // Single read then single write
    start(3'd2, 1'b0, 8'h00, 1);
    @(negedge CLK); b4.Acceso = 1'b0;
    wait_frw("rd_frw_timeout");
    @(negedge CLK);
    chk("rd_frw_gone", b4.FRW, 0);
    chk("rdata_hold", b4.RDATA, 8'h59);

    start(3'd3, 1'b1, 8'h12, 1);
    @(negedge CLK); b4.Acceso = 1'b0;
    wait_frw("wr_frw_timeout");
    @(negedge CLK);
    chk("wr_rdata_kept", b4.RDATA, 8'h59);

    // Back-to-back with Acceso held, DIR stepped on each FRW
    rd_val = 8'h51;
    start(3'd1, 1'b0, 8'h00, 1);
    for (int d = 2; d <= 8; d++) begin
      wait_frw("b2b_frw_timeout");
      if (d <= 7) begin
        rd_val = 8'h50 + 8'(d);
        start(3'(d), 1'b0, 8'h00, 1);
        @(negedge CLK); chk("b2b_idle_gap", b4.BUSY, 0);
        @(negedge CLK); chk("b2b_restart", b4.BUSY, 1);
      end else begin
        b4.Acceso = 1'b0;
      end
    end
    repeat (2) begin
      @(negedge CLK);
      chk("b2b_stopped", b4.BUSY, 0);
    end

    // Reset during the data strobe of a write
    start(3'd5, 1'b1, 8'h34, 0);
    @(negedge CLK); b4.Acceso = 1'b0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge CLK);
      hit = !b4.WR_n && b4.AD_n;
    end
    chk("abort_reach_strobe", hit, 1);
    RST = 1'b0;
    @(negedge CLK);
    chk("abort_outputs", {b4.WR_n, b4.RD_n, b4.CS_n, b4.AD_OE, b4.FRW}, 5'b11100);
    RST = 1'b1;
    frw_seen = 0;
    repeat (35) begin
      @(negedge CLK);
      frw_seen |= b4.FRW;
    end
    chk("abort_no_frw", frw_seen, 0);

    // T_PHASE=1 read of the command register
    b1.DIR = 3'd0; b1.Mod = 1'b0; b1.Acceso = 1'b1; t0 = cyc;
    @(negedge CLK); b1.Acceso = 1'b0;
    n_rd = 0; n_wr = 0; n_rv = 0; a1 = 8'h00; r1 = 8'h00; hit = 0;
    for (int i = 0; i < 15 && !hit; i++) begin
      @(negedge CLK);
      if (!b1.CS_n && !b1.AD_n && b1.AD_OE) a1 = b1.AD_OUT;
      if (!b1.RD_n) n_rd++;
      if (!b1.WR_n) n_wr++;
      if (b1.RVALID) begin n_rv++; r1 = b1.RDATA; end
      hit = b1.FRW;
    end
    chk("t1_frw_seen", hit, 1);
    chk("t1_frw_latency", cyc, t0 + 9);
    chk("t1_addr", a1, 8'hF0);
    chk("t1_rd_width", n_rd, 1);
    chk("t1_wr_width", n_wr, 1);
    chk("t1_rvalid", n_rv, 1);
    chk("t1_rdata", r1, 8'hA5);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
